// File: rtl/snes_pkg.sv
// Shared types and constants for the SNES/NES controller poller.
// Bit indices follow the order buttons are shifted out of a SNES pad.
package snes_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        WAIT0,
        CLK_LO,
        CLK_HI,
        DONE
    } pad_state_t;

    localparam int SNES_BITS = 16;
    localparam int NES_BITS  = 8;

    localparam int BTN_B      = 0;
    localparam int BTN_Y      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;
    localparam int BTN_A      = 8;
    localparam int BTN_X      = 9;
    localparam int BTN_L      = 10;
    localparam int BTN_R      = 11;

endpackage

// File: rtl/pad_shift_channel.sv
// Per-connector capture: 2-flop synchroniser, LSB-first shift register, button register and change flag.
// Latency: sampled bit lands in the shift register next cycle; buttons/changed update the cycle after commit.
// No backpressure: strobes from the poller FSM are obeyed unconditionally.
module pad_shift_channel #(
    parameter int NUM_BITS = 16,
    parameter int BW       = 4
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                data,
    input  logic                sample,
    input  logic                commit,
    input  logic [BW-1:0]       bit_idx,
    output logic [NUM_BITS-1:0] buttons,
    output logic                changed
);

    logic                sync1, sync2;
    logic [NUM_BITS-1:0] shreg, shreg_n;

    // Commit happens on the same cycle as the final sample, so it must see the merged value.
    always_comb begin
        shreg_n = shreg;
        if (sample) shreg_n[bit_idx] = sync2;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            shreg   <= '1;
            buttons <= '0;
            changed <= 1'b0;
        end else begin
            sync1 <= data;
            sync2 <= sync1;
            shreg <= shreg_n;
            if (commit) begin
                buttons <= ~shreg_n;
                changed <= (~shreg_n != buttons);
            end
        end
    end

endmodule

// File: rtl/snes_pad_poller.sv
// N-player SNES/NES pad poller: one FSM drives latch/shift-clock for all connectors and commits per-frame button vectors.
// Latency: Buttons_Valid 3H+(NUM_BITS-1)*2H+1 cycles after an accepted trigger; all outputs registered.
// No backpressure: triggers arriving outside IDLE are dropped, never queued.
module snes_pad_poller
    import snes_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int NUM_BITS    = 16,
    parameter int HALF_PERIOD = 150,
    parameter int POLL_DIV    = 416667,
    parameter int SYNC_MODE   = 0
) (
    input  logic                            Clock,
    input  logic                            Reset,
    input  logic                            Poll_Req,
    input  logic [NUM_PLAYERS-1:0]          Data,
    output logic [NUM_PLAYERS-1:0]          NStrobe_Latch,
    output logic [NUM_PLAYERS-1:0]          NShift_Clock,
    output logic [NUM_PLAYERS*NUM_BITS-1:0] Buttons,
    output logic                            Buttons_Valid,
    output logic [NUM_PLAYERS-1:0]          Changed,
    output logic                            Busy
);

    localparam int BW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
    localparam int CW = $clog2(2 * HALF_PERIOD);
    localparam int TW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;

    localparam logic [CW-1:0] HALF_LAST  = CW'(HALF_PERIOD - 1);
    localparam logic [CW-1:0] LATCH_LAST = CW'(2 * HALF_PERIOD - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(NUM_BITS - 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(POLL_DIV - 1);

    pad_state_t    state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [BW-1:0] bit_idx, bit_idx_n;
    logic [TW-1:0] timer;
    logic          trigger, sample, commit;
    logic          latch_q, sclk_q, busy_q, valid_q;

    assign trigger = (SYNC_MODE != 0) ? Poll_Req : (timer == TIMER_LAST);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)                    timer <= '0;
        else if (timer == TIMER_LAST) timer <= '0;
        else                          timer <= timer + 1'b1;
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt + 1'b1;
        bit_idx_n = bit_idx;
        sample    = 1'b0;
        case (state)
            IDLE: begin
                cnt_n     = '0;
                bit_idx_n = '0;
                if (trigger) state_n = LATCH;
            end
            LATCH: begin
                if (cnt == LATCH_LAST) begin
                    cnt_n   = '0;
                    state_n = WAIT0;
                end
            end
            WAIT0: begin
                if (cnt == HALF_LAST) begin
                    cnt_n  = '0;
                    sample = 1'b1;
                    if (bit_idx == BIT_LAST) begin
                        state_n = DONE;
                    end else begin
                        bit_idx_n = bit_idx + 1'b1;
                        state_n   = CLK_LO;
                    end
                end
            end
            CLK_LO: begin
                if (cnt == HALF_LAST) begin
                    cnt_n   = '0;
                    state_n = CLK_HI;
                end
            end
            CLK_HI: begin
                // Pad has had a full half period to present the bit shifted out on the rising edge.
                if (cnt == HALF_LAST) begin
                    cnt_n  = '0;
                    sample = 1'b1;
                    if (bit_idx == BIT_LAST) begin
                        state_n = DONE;
                    end else begin
                        bit_idx_n = bit_idx + 1'b1;
                        state_n   = CLK_LO;
                    end
                end
            end
            DONE: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    assign commit = sample && (state_n == DONE);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            latch_q <= 1'b1;
            sclk_q  <= 1'b1;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            latch_q <= (state_n != LATCH);
            sclk_q  <= (state_n != CLK_LO);
            busy_q  <= (state_n != IDLE);
            valid_q <= (state_n == DONE);
        end
    end

    assign NStrobe_Latch = {NUM_PLAYERS{latch_q}};
    assign NShift_Clock  = {NUM_PLAYERS{sclk_q}};
    assign Busy          = busy_q;
    assign Buttons_Valid = valid_q;

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_chan
        pad_shift_channel #(
            .NUM_BITS (NUM_BITS),
            .BW       (BW)
        ) u_chan (
            .Clock   (Clock),
            .Reset   (Reset),
            .data    (Data[p]),
            .sample  (sample),
            .commit  (commit),
            .bit_idx (bit_idx),
            .buttons (Buttons[p*NUM_BITS +: NUM_BITS]),
            .changed (Changed[p])
        );
    end

endmodule

// File: tb/tb_snes_pad_poller.sv
// Directed bench: 2-player SNES poller on request, plus 4-player NES poller on its free-running timer.
module tb_snes_pad_poller;
    import snes_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 2-player, H=4, 16 bits, poll on request
    logic        rst, poll_req;
    logic [1:0]  data, lat, sc, chg;
    logic [31:0] btn;
    logic        vld, busy;

    // 4-player, H=4, 8 bits, free-running every 300 cycles
    logic        rst2, poll_req2;
    logic [3:0]  data2, lat2, sc2, chg2;
    logic [31:0] btn2;
    logic        vld2, busy2;

    snes_pad_poller #(.NUM_PLAYERS(2), .NUM_BITS(16), .HALF_PERIOD(4), .POLL_DIV(300), .SYNC_MODE(1)) dut (
        .Clock(clk), .Reset(rst), .Poll_Req(poll_req), .Data(data),
        .NStrobe_Latch(lat), .NShift_Clock(sc), .Buttons(btn),
        .Buttons_Valid(vld), .Changed(chg), .Busy(busy));

    snes_pad_poller #(.NUM_PLAYERS(4), .NUM_BITS(8), .HALF_PERIOD(4), .POLL_DIV(300), .SYNC_MODE(0)) dut2 (
        .Clock(clk), .Reset(rst2), .Poll_Req(poll_req2), .Data(data2),
        .NStrobe_Latch(lat2), .NShift_Clock(sc2), .Buttons(btn2),
        .Buttons_Valid(vld2), .Changed(chg2), .Busy(busy2));

    // Pad model: latch low reloads bit 0, each rising shift clock advances one bit.
    logic [15:0] raw [2];
    logic [4:0]  idx [2];
    logic [1:0]  sc_prev;

    always @(posedge clk) begin
        sc_prev <= sc;
        for (int p = 0; p < 2; p++) begin
            if (rst || !lat[p])           idx[p] <= 5'd0;
            else if (sc[p] && !sc_prev[p]) idx[p] <= idx[p] + 5'd1;
        end
    end

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            data[p] = (idx[p] < 5'd16) ? raw[p][idx[p][3:0]] : 1'b1;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Poll observations
    int lat_first, lat_last, lat_cnt, sc_low, sc_fall;
    int vld_first, vld_count, busy_first, busy_last;
    logic        split_bad;
    logic [31:0] btn_at_vld;
    logic [1:0]  chg_at_vld;
    logic [1:0]  rst_lat, rst_sc;
    logic [31:0] rst_btn;
    logic        rst_busy;

    // Trigger during cycle 0, then observe cycles 1..ncyc; optional extra requests and a mid-poll reset.
    task automatic poll(input int req_a, input int req_b, input int rst_at, input int ncyc);
        logic sc_p;
        lat_first = -1; lat_last = -1; lat_cnt = 0; sc_low = 0; sc_fall = 0;
        vld_first = -1; vld_count = 0; busy_first = -1; busy_last = -1;
        split_bad = 1'b0; btn_at_vld = '0; chg_at_vld = '0;
        sc_p = 1'b1;
        poll_req = 1'b1;
        step();
        for (int c = 1; c <= ncyc; c++) begin
            poll_req = (c == req_a || c == req_b);
            if (c == rst_at) begin
                rst = 1'b1;
                #1;
                rst_lat = lat; rst_sc = sc; rst_btn = btn; rst_busy = busy;
                rst = 1'b0;
                poll_req = 1'b0;
                return;
            end
            if (lat[0] !== lat[1] || sc[0] !== sc[1]) split_bad = 1'b1;
            if (lat[0] == 1'b0) begin
                lat_cnt++;
                if (lat_first < 0) lat_first = c;
                lat_last = c;
            end
            if (sc[0] == 1'b0) sc_low++;
            if (sc_p == 1'b1 && sc[0] == 1'b0) sc_fall++;
            sc_p = sc[0];
            if (busy == 1'b1) begin
                if (busy_first < 0) busy_first = c;
                busy_last = c;
            end
            if (vld == 1'b1) begin
                vld_count++;
                if (vld_first < 0) begin
                    vld_first  = c;
                    btn_at_vld = btn;
                    chg_at_vld = chg;
                end
            end
            step();
        end
        poll_req = 1'b0;
    endtask

    logic [31:0] exp_btn;
    logic        idle_ok;
    int          v2_cnt;
    int          v2_at [4];
    logic [31:0] b2_at [2];
    logic [3:0]  c2_at [2];

    initial begin
        rst = 1'b1; rst2 = 1'b1; poll_req = 1'b0; poll_req2 = 1'b0;
        raw[0] = 16'hFFFE;   // B pressed
        raw[1] = 16'hFF7F;   // RIGHT pressed
        data2  = 4'b1110;    // player 0 line stuck low, others disconnected
        exp_btn = {16'(1) << BTN_RIGHT, 16'(1) << BTN_B};
        repeat (3) step();

        chk("reset_latch", lat, 2'b11);
        chk("reset_shclk", sc, 2'b11);
        chk("reset_buttons", btn, 32'h0);
        chk("reset_valid", vld, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_changed", chg, 2'b00);

        rst = 1'b0;
        idle_ok = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (lat !== 2'b11 || sc !== 2'b11 || btn !== 32'h0 || busy !== 1'b0) idle_ok = 1'b0;
            step();
        end
        chk("idle_quiet", idle_ok, 1'b1);

        // First poll: waveform timing and first capture
        poll(0, 0, 0, 140);
        chk("p1_latch_first", lat_first, 1);
        chk("p1_latch_last", lat_last, 8);
        chk("p1_latch_cycles", lat_cnt, 8);
        chk("p1_shclk_pulses", sc_fall, 15);
        chk("p1_shclk_low_cycles", sc_low, 60);
        chk("p1_lines_identical", split_bad, 1'b0);
        chk("p1_valid_count", vld_count, 1);
        chk("p1_valid_cycle", vld_first, 133);
        chk("p1_busy_first", busy_first, 1);
        chk("p1_busy_last", busy_last, 133);
        chk("p1_buttons", btn_at_vld, exp_btn);
        chk("p1_changed", chg_at_vld, 2'b11);

        // Identical poll with requests mid-poll and on the DONE cycle
        poll(50, 133, 0, 300);
        chk("p2_valid_count", vld_count, 1);
        chk("p2_valid_cycle", vld_first, 133);
        chk("p2_busy_last", busy_last, 133);
        chk("p2_buttons", btn_at_vld, exp_btn);
        chk("p2_changed", chg_at_vld, 2'b00);
        chk("p2_buttons_hold", btn, exp_btn);

        // Reset in the middle of a poll
        poll(0, 0, 70, 100);
        chk("rst_mid_latch", rst_lat, 2'b11);
        chk("rst_mid_shclk", rst_sc, 2'b11);
        chk("rst_mid_buttons", rst_btn, 32'h0);
        chk("rst_mid_busy", rst_busy, 1'b0);
        step(); step();

        poll(0, 0, 0, 140);
        chk("p3_valid_count", vld_count, 1);
        chk("p3_valid_cycle", vld_first, 133);
        chk("p3_buttons", btn_at_vld, exp_btn);
        chk("p3_changed", chg_at_vld, 2'b11);

        // Free-running 4-player NES poller: wraps at cycle 299, 599, 899
        v2_cnt = 0;
        rst2 = 1'b0;
        chk("fr_reset_latch", lat2, 4'hF);
        chk("fr_reset_shclk", sc2, 4'hF);
        chk("fr_reset_busy", busy2, 1'b0);
        for (int k = 0; k <= 1000; k++) begin
            if (vld2 == 1'b1) begin
                if (v2_cnt < 4) v2_at[v2_cnt] = k;
                if (v2_cnt < 2) begin
                    b2_at[v2_cnt] = btn2;
                    c2_at[v2_cnt] = chg2;
                end
                v2_cnt++;
            end
            step();
        end
        chk("fr_valid_count", v2_cnt, 3);
        if (v2_cnt >= 3) begin
            chk("fr_valid_first", v2_at[0], 368);
            chk("fr_valid_second", v2_at[1], 668);
            chk("fr_valid_third", v2_at[2], 968);
            chk("fr_buttons_first", b2_at[0], 32'h0000_00FF);
            chk("fr_changed_first", c2_at[0], 4'b0001);
            chk("fr_buttons_second", b2_at[1], 32'h0000_00FF);
            chk("fr_changed_second", c2_at[1], 4'b0000);
        end else begin
            bad++;
            $error("FAIL fr_valid_timeout: got %0d pulses expected 3", v2_cnt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/snes_pad_poller.md
Name: snes_pad_poller

Overview:
- Parametrised N-player SNES/NES controller poller.
- Generates latch and shift-clock waveforms and samples each player's serial data line.
- Publishes debounced-by-frame button vectors to the game logic.
- Sits between the controller connectors and the per-player movement logic. It replaces ad-hoc per-player readers and adds frame-synchronised polling, change flags and an arbitrary player count.

Parameters:
- NUM_PLAYERS, 2, number of controller channels.
- NUM_BITS, 16, serial bits per poll (16 = SNES, 8 = NES).
- HALF_PERIOD, 150, clock cycles per shift-clock half period (6 us at 25 MHz). Must be >= 4.
- POLL_DIV, 416667, cycles between polls in free-running mode (60 Hz at 25 MHz).
- SYNC_MODE, 0, 0 = free-running poll timer; 1 = poll only on Poll_Req.

Ports:
- Clock  in  1  system/pixel clock.
- Reset  in  1  asynchronous, active-high reset.
- Poll_Req  in  1  single-cycle poll request, e.g. start of vertical blank. Used only when SYNC_MODE=1.
- Data  in  NUM_PLAYERS  raw serial data per player; asynchronous; button pressed = 0.
- NStrobe_Latch  out  NUM_PLAYERS  latch strobe per connector; idles high, driven low to latch. All bits identical.
- NShift_Clock  out  NUM_PLAYERS  shift clock per connector; idles high. All bits identical.
- Buttons  out  NUM_PLAYERS*NUM_BITS  player p, bit i at index p*NUM_BITS+i; 1 = pressed.
- Buttons_Valid  out  1  one-cycle pulse when Buttons has just been updated.
- Changed  out  NUM_PLAYERS  per player; valid with Buttons_Valid; 1 if the new vector differs from the previous one.
- Busy  out  1  high from poll acceptance until Buttons_Valid, inclusive.

Behaviour:
- Reset values:
  - NStrobe_Latch and NShift_Clock all ones.
  - Buttons, Changed, Buttons_Valid and Busy all zero.
  - FSM in IDLE; poll timer and bit counter zero.
- Synchronisation: each Data bit passes through a 2-flop synchroniser before sampling.
- Poll trigger:
  - SYNC_MODE=0: the poll timer counts 0..POLL_DIV-1 and wraps; a trigger fires on wrap.
  - SYNC_MODE=1: the trigger is Poll_Req.
  - A trigger is accepted only in IDLE. Triggers while Busy are dropped, not queued.
- FSM states: IDLE, LATCH, WAIT0, CLK_LO, CLK_HI, DONE. A half-period counter runs 0..HALF_PERIOD-1.
- Timing, with the trigger accepted on cycle 0 and H = HALF_PERIOD:
  - LATCH: NStrobe_Latch low for cycles 1..2H.
  - WAIT0: cycles 2H+1..3H, all outputs high. Sample bit 0 on cycle 3H.
  - For bits i = 1..NUM_BITS-1:
    - CLK_LO: NShift_Clock low for H cycles.
    - CLK_HI: NShift_Clock high for H cycles.
    - Sample bit i on the last CLK_HI cycle.
  - NUM_BITS-1 clock pulses are issued in total.
  - DONE: the cycle after the last sample, i.e. cycle 3H+(NUM_BITS-1)*2H+1.
- DONE actions:
  - Buttons <= inverted shift registers.
  - Changed[p] <= (new vector != old Buttons slice).
  - Buttons_Valid = 1 for exactly that cycle.
  - Return to IDLE on the next cycle.
  - Busy drops the cycle after DONE.
- Shift capture: sampled bit i is stored at position i; LSB first.
- Outputs are registered; no combinational path from Data to any output.
- Hold: Buttons holds its value between polls. Changed is meaningful only while Buttons_Valid is high and holds otherwise.
- Disconnected connector: an idle-high line reads all ones, so Buttons slice = 0 and there is no error flag.
- Reset mid-poll: immediately forces idle-high waveforms and IDLE, and clears Buttons. In SYNC_MODE=0 the poll timer restarts from 0.
- Poll_Req on the same cycle as DONE is dropped.

Decomposition:
- Shared package snes_pkg:
  - state enum pad_state_t.
  - SNES bit-index constants (B=0, Y=1, SELECT=2, START=3, UP=4, DOWN=5, LEFT=6, RIGHT=7, A=8, X=9, L=10, R=11).
  - SNES_BITS=16, NES_BITS=8.
- One sub-module, pad_shift_channel, instantiated NUM_PLAYERS times by a generate loop. Each instance holds the synchroniser, the NUM_BITS shift register, the output register and change detection. It is driven by shared sample/commit strobes from the single FSM.

Test Plan:
- Reset then idle, NUM_PLAYERS=2, H=4, NUM_BITS=16, SYNC_MODE=1, no Poll_Req for 200 cycles -> NStrobe_Latch=2'b11, NShift_Clock=2'b11, Buttons=0, Busy=0 throughout.
- Poll_Req at cycle 0 -> NStrobe_Latch low for cycles 1..8; 15 NShift_Clock low pulses of 4 cycles each; Buttons_Valid single pulse at cycle 133; Busy high for cycles 1..133.
- Player model: P1 serialises raw 16'hFFFE (B pressed), P2 serialises 16'hFF7F (RIGHT pressed) -> Buttons[15:0]=16'h0001, Buttons[31:16]=16'h0080, Changed=2'b11. An identical second poll gives Changed=2'b00 with the same Buttons.
- Poll_Req pulsed again at cycle 50 during a poll -> ignored; exactly one Buttons_Valid occurs, at cycle 133.
- Reset asserted at cycle 70 mid-poll -> on the same cycle both strobe outputs go high and Buttons=0. A new Poll_Req completes normally with 133-cycle latency.
- SYNC_MODE=0, POLL_DIV=300, NUM_BITS=8, NUM_PLAYERS=4 -> Buttons_Valid pulses every 300 cycles at 3H+7*2H+1=69 cycles after each timer wrap, with an all-ones line giving Buttons slice 8'h00.
